// File: rtl/im_loader.sv
// im_loader: streaming program loader for the single-cycle CPU instruction memory.
// Accepts 32-bit words on a valid/ready stream, writes them to consecutive
// instruction-memory word addresses, and holds the CPU in reset until the
// image is complete.
//
// Optional feature macro: IM_LOADER_CHECKSUM_EN
//   defined   -> the in_last beat is a checksum (not written); the mod-2^32 sum
//                of written words must match it or the load ends in ERR.
//   undefined -> the in_last beat is an ordinary instruction word.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        single-cycle request to begin a new load (ignored while busy)
//   in_valid     stream word valid
//   in_ready     loader accepts a word this cycle (LOAD only)
//   in_data      instruction word (or checksum)
//   in_last      final beat of the image
//   im_we        instruction memory write enable (registered)
//   im_addr      instruction memory word address (registered)
//   im_wdata     instruction memory write data (registered)
//   cpu_reset_n  active-low CPU reset, high only in RUN
//   busy         high in LOAD and FLUSH
//   done         one-cycle pulse on entering RUN
//   error        sticky overflow / checksum error, cleared by start or reset
//   word_count   words written in the current load, saturates at 2^ADDR_WIDTH
module im_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;

  // Capacity in words; word_count never exceeds this value.
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  data_beat;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  // A beat carries an instruction unless it is the checksum beat.
`ifdef IM_LOADER_CHECKSUM_EN
  assign data_beat = !in_last;
`else
  assign data_beat = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    error_d = error_q;
    done_d  = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (data_beat) begin
            if (count_q != CAP) begin
              we_d    = 1'b1;
              addr_d  = count_q[ADDR_WIDTH-1:0];
              wdata_d = in_data;
              count_d = count_q + (ADDR_WIDTH+1)'(1);
`ifdef IM_LOADER_CHECKSUM_EN
              sum_d   = sum_q + in_data;
`endif
            end else begin
              error_d = 1'b1;
            end
          end
`ifdef IM_LOADER_CHECKSUM_EN
          else if (sum_q != in_data) begin
            error_d = 1'b1;
          end
`endif
          if (in_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (error_q) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          error_d = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      error_q <= error_d;
      done_q  <= done_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign cpu_reset_n = (state_q == S_RUN);
  assign im_we       = we_q;
  assign im_addr     = addr_q;
  assign im_wdata    = wdata_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: two instances (ADDR_WIDTH 10 and 2) share one stimulus
// stream; each is checked every cycle against a behavioural loader model, and
// the memory each one writes is compared with the expected image.
module tb_im_loader;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FLUSH = 2, PH_RUN = 3, PH_ERR = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;

  logic        rdy0, we0, crn0, busy0, done0, err0;
  logic [9:0]  addr0;
  logic [31:0] wd0;
  logic [10:0] cnt0;
  logic        rdy1, we1, crn1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;

  always #5 clock = ~clock;

  im_loader #(.ADDR_WIDTH(10)) dut0 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .in_last(in_last), .im_we(we0),
    .im_addr(addr0), .im_wdata(wd0), .cpu_reset_n(crn0), .busy(busy0),
    .done(done0), .error(err0), .word_count(cnt0)
  );

  im_loader #(.ADDR_WIDTH(2)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .in_last(in_last), .im_we(we1),
    .im_addr(addr1), .im_wdata(wd1), .cpu_reset_n(crn1), .busy(busy1),
    .done(done1), .error(err1), .word_count(cnt1)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state, one slot per instance.
  int          m_phase [2];
  int unsigned m_count [2];
  bit          m_err   [2];
  logic [31:0] m_sum   [2];
  int unsigned cap     [2] = '{1024, 4};
  logic [31:0] exp_mem [2][1024];
  logic [31:0] dut_mem [2][1024];
  logic [31:0] img [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int k, output logic o_we, output logic [31:0] o_addr,
                         output logic [31:0] o_data, output logic o_rdy, output logic o_crn,
                         output logic o_busy, output logic o_done, output logic o_err,
                         output logic [31:0] o_cnt);
    if (k == 0) begin
      o_we = we0; o_addr = 32'(addr0); o_data = wd0; o_rdy = rdy0; o_crn = crn0;
      o_busy = busy0; o_done = done0; o_err = err0; o_cnt = 32'(cnt0);
    end else begin
      o_we = we1; o_addr = 32'(addr1); o_data = wd1; o_rdy = rdy1; o_crn = crn1;
      o_busy = busy1; o_done = done1; o_err = err1; o_cnt = 32'(cnt1);
    end
  endtask

  // One clock cycle: advance the model on the current inputs, then check all outputs.
  task automatic step();
    bit          e_we   [2];
    bit          e_done [2];
    int unsigned e_addr [2];
    logic [31:0] e_data [2];
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 1'b0; e_done[k] = 1'b0; e_addr[k] = 0; e_data[k] = '0;
      case (m_phase[k])
        PH_LOAD: begin
          if (in_valid) begin
            if (CSUM && in_last) begin
              if (m_sum[k] !== in_data) m_err[k] = 1'b1;
            end else if (m_count[k] < cap[k]) begin
              e_we[k] = 1'b1;
              e_addr[k] = m_count[k];
              e_data[k] = in_data;
              exp_mem[k][m_count[k]] = in_data;
              m_count[k]++;
              m_sum[k] = m_sum[k] + in_data;
            end else begin
              m_err[k] = 1'b1;
            end
            if (in_last) m_phase[k] = PH_FLUSH;
          end
        end
        PH_FLUSH: begin
          e_done[k] = !m_err[k];
          m_phase[k] = m_err[k] ? PH_ERR : PH_RUN;
        end
        default: begin
          if (start) begin
            m_phase[k] = PH_LOAD;
            m_count[k] = 0;
            m_err[k] = 1'b0;
            m_sum[k] = '0;
          end
        end
      endcase
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      logic o_we, o_rdy, o_crn, o_busy, o_done, o_err;
      logic [31:0] o_addr, o_data, o_cnt;
      get_obs(k, o_we, o_addr, o_data, o_rdy, o_crn, o_busy, o_done, o_err, o_cnt);
      chk($sformatf("d%0d_im_we", k), 32'(o_we), 32'(e_we[k]));
      if (e_we[k]) begin
        chk($sformatf("d%0d_im_addr", k), o_addr, e_addr[k]);
        chk($sformatf("d%0d_im_wdata", k), o_data, e_data[k]);
      end
      chk($sformatf("d%0d_in_ready", k), 32'(o_rdy), 32'(m_phase[k] == PH_LOAD));
      chk($sformatf("d%0d_cpu_reset_n", k), 32'(o_crn), 32'(m_phase[k] == PH_RUN));
      chk($sformatf("d%0d_busy", k), 32'(o_busy),
          32'(m_phase[k] == PH_LOAD || m_phase[k] == PH_FLUSH));
      chk($sformatf("d%0d_done", k), 32'(o_done), 32'(e_done[k]));
      chk($sformatf("d%0d_error", k), 32'(o_err), 32'(m_err[k]));
      chk($sformatf("d%0d_word_count", k), o_cnt, m_count[k]);
      if (o_we === 1'b1 && o_addr < 1024) dut_mem[k][o_addr] = o_data;
    end
  endtask

  task automatic check_mem();
    for (int k = 0; k < 2; k++) begin
      int mism = 0;
      for (int unsigned i = 0; i < cap[k]; i++)
        if (dut_mem[k][i] !== exp_mem[k][i]) mism++;
      chk($sformatf("d%0d_mem_image", k), 32'(mism), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic o_we, o_rdy, o_crn, o_busy, o_done, o_err;
      logic [31:0] o_addr, o_data, o_cnt;
      get_obs(k, o_we, o_addr, o_data, o_rdy, o_crn, o_busy, o_done, o_err, o_cnt);
      chk($sformatf("%s_d%0d_outs", tag, k),
          {25'd0, o_we, o_rdy, o_crn, o_busy, o_done, o_err, 1'b0}, 32'd0);
      chk($sformatf("%s_d%0d_addr", tag, k), o_addr, 32'd0);
      chk($sformatf("%s_d%0d_wdata", tag, k), o_data, 32'd0);
      chk($sformatf("%s_d%0d_count", tag, k), o_cnt, 32'd0);
    end
  endtask

  // vmode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
  task automatic run_load(input int vmode, input bit mid_start);
    int unsigned i = 0;
    int guard = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (i < img.size() && guard < 400) begin
      logic v;
      case (vmode)
        0: v = 1'b1;
        1: v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data = v ? img[i] : $urandom;
      in_last = (i == img.size() - 1);
      start = mid_start && (guard == 3);
      step();
      if (v) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    repeat (3) step();
    check_mem();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = PH_IDLE; m_count[k] = 0; m_err[k] = 1'b0; m_sum[k] = '0;
      for (int i = 0; i < 1024; i++) begin
        exp_mem[k][i] = '0;
        dut_mem[k][i] = '0;
      end
    end

    // Power-on reset
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("por");
    @(posedge clock);
    #1 reset = 1'b1;
    step();

    // Reference program, continuous valid (small instance overflows)
    img = '{32'h00225821, 32'h01635823, 32'h0164a821, 32'h00a6582a, 32'h00c5602a,
            32'h016cb023, 32'h00e85824, 32'h012a6024, 32'h016cb825};
    run_load(0, 1'b0);

    // Stream beats outside LOAD are ignored
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'hdeadbeef;
    repeat (3) step();
    in_valid = 1'b0; in_last = 1'b0;

    // Same program, gapped valid and a start pulse mid-load (from RUN / ERR)
    run_load(1, 1'b1);

    // Checksum images: good sum, then bad sum
    img = '{32'h1, 32'h2, 32'h3};
    run_load(0, 1'b0);
    img = '{32'h1, 32'h2, 32'h4};
    run_load(0, 1'b0);

    // Asynchronous reset after three accepted beats
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = 32'hA500_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = PH_IDLE; m_count[k] = 0; m_err[k] = 1'b0; m_sum[k] = '0;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    step();
    check_mem();
    img = '{32'h0BAD_F00D, 32'h1234_5678};
    run_load(0, 1'b0);

    // Randomized images
    for (int t = 0; t < 10; t++) begin
      int n = $urandom_range(1, 10);
      logic [31:0] s = '0;
      img.delete();
      for (int i = 0; i < n; i++) begin
        logic [31:0] w = $urandom;
        if (i < n - 1) s = s + w;
        img.push_back(w);
      end
      if (CSUM && n > 1 && $urandom_range(0, 1) == 1) img[n-1] = s;
      run_load(2, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
